mem_arbiter: RTL and testbench

Two-client arbiter that shares the single main-memory port between the instruction cache (`ic_`) and the data cache (`dc_`). It sits between the two cache instances and the memory interface in the top level. It grants one whole line transaction at a time: a request handshake, then the write-data beats or the read-response beats. The memory port is held locked to the winner until the transaction's last beat, so every response beat returns to the client that issued the request.

---
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the main-memory line port between the icache (ic_) and dcache (dc_) clients.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise dc has fixed priority over ic.
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif

module mem_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = `MEM_DATA_BITS,
    parameter int unsigned BEATS  = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                ic_req_valid,
    output logic                ic_req_ready,
    input  logic [ADDR_W-1:0]   ic_req_addr,
    input  logic                ic_req_rw,
    input  logic                ic_req_data_valid,
    output logic                ic_req_data_ready,
    input  logic [DATA_W-1:0]   ic_req_data_bits,
    input  logic [DATA_W/8-1:0] ic_req_data_mask,
    output logic                ic_resp_valid,
    output logic [DATA_W-1:0]   ic_resp_data,

    input  logic                dc_req_valid,
    output logic                dc_req_ready,
    input  logic [ADDR_W-1:0]   dc_req_addr,
    input  logic                dc_req_rw,
    input  logic                dc_req_data_valid,
    output logic                dc_req_data_ready,
    input  logic [DATA_W-1:0]   dc_req_data_bits,
    input  logic [DATA_W/8-1:0] dc_req_data_mask,
    output logic                dc_resp_valid,
    output logic [DATA_W-1:0]   dc_resp_data,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_rw,
    output logic                mem_req_data_valid,
    input  logic                mem_req_data_ready,
    output logic [DATA_W-1:0]   mem_req_data_bits,
    output logic [DATA_W/8-1:0] mem_req_data_mask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data
);

    localparam int unsigned BEAT_W = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;

    state_t              state, state_n;
    logic                gnt, gnt_n;
    logic [BEAT_W-1:0]   beat, beat_n;
    logic                pick;

    logic                g_valid;
    logic [ADDR_W-1:0]   g_addr;
    logic                g_rw;
    logic                g_dvalid;
    logic [DATA_W-1:0]   g_dbits;
    logic [DATA_W/8-1:0] g_dmask;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic rr, rr_n;
    assign pick = (ic_req_valid && dc_req_valid) ? rr : dc_req_valid;
`else
    assign pick = dc_req_valid;
`endif

    assign g_valid  = gnt ? dc_req_valid      : ic_req_valid;
    assign g_addr   = gnt ? dc_req_addr       : ic_req_addr;
    assign g_rw     = gnt ? dc_req_rw         : ic_req_rw;
    assign g_dvalid = gnt ? dc_req_data_valid : ic_req_data_valid;
    assign g_dbits  = gnt ? dc_req_data_bits  : ic_req_data_bits;
    assign g_dmask  = gnt ? dc_req_data_mask  : ic_req_data_mask;

    assign ic_resp_data = mem_resp_data;
    assign dc_resp_data = mem_resp_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            gnt   <= 1'b0;
            beat  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr    <= 1'b1;
`endif
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            beat  <= beat_n;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr    <= rr_n;
`endif
        end
    end

    always_comb begin
        state_n            = state;
        gnt_n              = gnt;
        beat_n             = beat;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_n               = rr;
`endif
        ic_req_ready       = 1'b0;
        dc_req_ready       = 1'b0;
        ic_req_data_ready  = 1'b0;
        dc_req_data_ready  = 1'b0;
        ic_resp_valid      = 1'b0;
        dc_resp_valid      = 1'b0;
        mem_req_valid      = 1'b0;
        mem_req_addr       = '0;
        mem_req_rw         = 1'b0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;

        case (state)
            IDLE: begin
                if (ic_req_valid || dc_req_valid) begin
                    gnt_n   = pick;
                    state_n = REQ;
                end
            end
            REQ: begin
                mem_req_valid = g_valid;
                mem_req_addr  = g_addr;
                mem_req_rw    = g_rw;
                ic_req_ready  = !gnt && mem_req_ready;
                dc_req_ready  =  gnt && mem_req_ready;
                // A withdrawn request abandons the grant without touching memory.
                if (!g_valid) begin
                    state_n = IDLE;
                end else if (mem_req_ready) begin
                    state_n = g_rw ? WDATA : RDATA;
                    beat_n  = '0;
                end
            end
            WDATA: begin
                mem_req_data_valid = g_dvalid;
                mem_req_data_bits  = g_dbits;
                mem_req_data_mask  = g_dmask;
                ic_req_data_ready  = !gnt && mem_req_data_ready;
                dc_req_data_ready  =  gnt && mem_req_data_ready;
                if (g_dvalid && mem_req_data_ready) begin
                    beat_n = beat + BEAT_W'(1);
                    if (beat == LAST_BEAT) begin
                        beat_n  = '0;
                        state_n = IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        rr_n    = ~rr;
`endif
                    end
                end
            end
            RDATA: begin
                ic_resp_valid = !gnt && mem_resp_valid;
                dc_resp_valid =  gnt && mem_resp_valid;
                if (mem_resp_valid) begin
                    beat_n = beat + BEAT_W'(1);
                    if (beat == LAST_BEAT) begin
                        beat_n  = '0;
                        state_n = IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        rr_n    = ~rr;
`endif
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model checked every cycle plus directed tests.
// Build with MEM_ARB_ROUND_ROBIN_EN to exercise the round-robin tie-break expectations.
module tb_mem_arbiter;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int MW     = DATA_W / 8;
    localparam int BEATS  = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic              ic_req_valid = 0, ic_req_rw = 0, ic_req_data_valid = 0;
    logic [ADDR_W-1:0] ic_req_addr = '0;
    logic [DATA_W-1:0] ic_req_data_bits = '0;
    logic [MW-1:0]     ic_req_data_mask = '0;
    logic              dc_req_valid = 0, dc_req_rw = 0, dc_req_data_valid = 0;
    logic [ADDR_W-1:0] dc_req_addr = '0;
    logic [DATA_W-1:0] dc_req_data_bits = '0;
    logic [MW-1:0]     dc_req_data_mask = '0;
    logic              mem_req_ready = 0, mem_req_data_ready = 0, mem_resp_valid = 0;
    logic [DATA_W-1:0] mem_resp_data = '0;

    logic              ic_req_ready, ic_req_data_ready, ic_resp_valid;
    logic              dc_req_ready, dc_req_data_ready, dc_resp_valid;
    logic [DATA_W-1:0] ic_resp_data, dc_resp_data;
    logic              mem_req_valid, mem_req_rw, mem_req_data_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data_bits;
    logic [MW-1:0]     mem_req_data_mask;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_req_rw(ic_req_rw), .ic_req_data_valid(ic_req_data_valid),
        .ic_req_data_ready(ic_req_data_ready), .ic_req_data_bits(ic_req_data_bits),
        .ic_req_data_mask(ic_req_data_mask), .ic_resp_valid(ic_resp_valid),
        .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
        .dc_req_rw(dc_req_rw), .dc_req_data_valid(dc_req_data_valid),
        .dc_req_data_ready(dc_req_data_ready), .dc_req_data_bits(dc_req_data_bits),
        .dc_req_data_mask(dc_req_data_mask), .dc_resp_valid(dc_resp_valid),
        .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    // {ic_rdy, dc_rdy, ic_drdy, dc_drdy, ic_rv, dc_rv, mem_v, mem_rw, mem_dv}
    logic [8:0] ctl;
    assign ctl = {ic_req_ready, dc_req_ready, ic_req_data_ready, dc_req_data_ready,
                  ic_resp_valid, dc_resp_valid, mem_req_valid, mem_req_rw, mem_req_data_valid};

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the port, whether its request was accepted, beats left.
    int owner = -1;
    bit hs = 1'b0;
    bit wr = 1'b0;
    int left = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    bit pref = 1'b1;
`endif

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner <= -1;
            hs    <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            pref  <= 1'b1;
`endif
        end else if (owner < 0) begin
            if (ic_req_valid || dc_req_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (ic_req_valid && dc_req_valid) owner <= pref ? 1 : 0;
                else owner <= dc_req_valid ? 1 : 0;
`else
                owner <= dc_req_valid ? 1 : 0;
`endif
                hs <= 1'b0;
            end
        end else if (!hs) begin
            if (!(owner == 1 ? dc_req_valid : ic_req_valid)) owner <= -1;
            else if (mem_req_ready) begin
                hs   <= 1'b1;
                wr   <= (owner == 1) ? dc_req_rw : ic_req_rw;
                left <= BEATS;
            end
        end else if (wr ? ((owner == 1 ? dc_req_data_valid : ic_req_data_valid) && mem_req_data_ready)
                        : mem_resp_valid) begin
            left <= left - 1;
            if (left == 1) begin
                owner <= -1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                pref  <= ~pref;
`endif
            end
        end
    end

    logic [8:0]           e_ctl;
    logic [ADDR_W-1:0]    e_addr;
    logic [DATA_W+MW-1:0] e_wd;

    always_comb begin
        e_ctl  = '0;
        e_addr = '0;
        e_wd   = '0;
        if (owner >= 0 && !hs) begin
            e_ctl[8] = (owner == 0) && mem_req_ready;
            e_ctl[7] = (owner == 1) && mem_req_ready;
            e_ctl[2] = (owner == 1) ? dc_req_valid : ic_req_valid;
            e_ctl[1] = (owner == 1) ? dc_req_rw : ic_req_rw;
            e_addr   = (owner == 1) ? dc_req_addr : ic_req_addr;
        end else if (owner >= 0 && wr) begin
            e_ctl[6] = (owner == 0) && mem_req_data_ready;
            e_ctl[5] = (owner == 1) && mem_req_data_ready;
            e_ctl[0] = (owner == 1) ? dc_req_data_valid : ic_req_data_valid;
            e_wd     = (owner == 1) ? {dc_req_data_bits, dc_req_data_mask}
                                    : {ic_req_data_bits, ic_req_data_mask};
        end else if (owner >= 0) begin
            e_ctl[4] = (owner == 0) && mem_resp_valid;
            e_ctl[3] = (owner == 1) && mem_resp_valid;
        end
    end

    always @(negedge clk) begin
        chk("cyc_ctl", ctl, e_ctl);
        chk("cyc_addr", mem_req_addr, e_addr);
        chk("cyc_wdata", {mem_req_data_bits, mem_req_data_mask}, e_wd);
        chk("cyc_rdata", {ic_resp_data, dc_resp_data}, {mem_resp_data, mem_resp_data});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] wbits(input int i);
        return {4{32'hD00D_0000 + i}};
    endfunction

    function automatic logic [MW-1:0] wmask(input int i);
        return 16'hA5C3 ^ 16'(i);
    endfunction

    // Waits for the next granted transaction and lets it finish; reports the winner.
    task automatic next_grant(output int who);
        int beats;
        beats = 0;
        who = -1;
        for (int c = 0; c < 30 && (who < 0 || beats < BEATS); c++) begin
            @(negedge clk);
            if (who < 0 && mem_req_valid && mem_req_ready) who = dc_req_ready ? 1 : 0;
            else if (who == 1 && dc_resp_valid) beats++;
            else if (who == 0 && ic_resp_valid) beats++;
            step();
        end
        chk("grant_beats", beats, BEATS);
    endtask

    initial begin
        int n, quiet, idx, who;
        int exp_order[4];

        // Reset state
        step();
        @(negedge clk);
        chk("rst_ctl", ctl, 9'd0);
        step();
        reset = 1'b1;
        step();

        // Single ic read
        ic_req_valid = 1; ic_req_addr = 28'h0000123; ic_req_rw = 0; mem_req_ready = 1;
        @(negedge clk);
        chk("rd_idle_ctl", ctl, 9'd0);
        step();
        @(negedge clk);
        chk("rd_addr", mem_req_addr, 28'h0000123);
        chk("rd_req", {mem_req_valid, mem_req_rw, ic_req_ready, dc_req_ready}, 4'b1010);
        step();
        ic_req_valid = 0;
        n = 0; quiet = 0;
        for (int i = 0; i < 6; i++) begin
            mem_resp_valid = (i < 4);
            mem_resp_data  = DATA_W'(32'hA0 + i);
            @(negedge clk);
            if (ic_resp_valid) begin
                chk("rd_beat", ic_resp_data, 32'hA0 + n);
                n++;
            end
            if (dc_resp_valid) quiet++;
            step();
        end
        chk("rd_count", n, 4);
        chk("rd_dc_quiet", quiet, 0);

        // dc write with toggling memory data ready
        dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h0ABCDEF;
        step();
        @(negedge clk);
        chk("wr_req", {mem_req_valid, mem_req_rw, ic_req_ready, dc_req_ready}, 4'b1101);
        chk("wr_addr", mem_req_addr, 28'h0ABCDEF);
        step();
        dc_req_valid = 0;
        idx = 0;
        for (int k = 0; k < 7; k++) begin
            mem_req_data_ready = (k % 2 == 0);
            dc_req_data_valid  = 1;
            dc_req_data_bits   = wbits(idx);
            dc_req_data_mask   = wmask(idx);
            @(negedge clk);
            chk("wr_rdy_mirror", {dc_req_data_ready, ic_req_data_ready}, {mem_req_data_ready, 1'b0});
            if (mem_req_data_valid && mem_req_data_ready) begin
                chk("wr_beat", {mem_req_data_bits, mem_req_data_mask}, {wbits(idx), wmask(idx)});
                idx++;
            end
            step();
        end
        dc_req_data_valid = 0; mem_req_data_ready = 0;
        chk("wr_count", idx, 4);
        @(negedge clk);
        chk("wr_idle", ctl, 9'd0);
        step();

        // Abort in REQ and stray response in IDLE
        ic_req_valid = 1; ic_req_rw = 0; mem_req_ready = 0; mem_resp_valid = 1;
        mem_resp_data = DATA_W'(32'hBAD);
        @(negedge clk);
        chk("stray_resp", {ic_resp_valid, dc_resp_valid}, 2'b00);
        step();
        ic_req_valid = 0; mem_req_ready = 1;
        @(negedge clk);
        chk("abort_no_req", mem_req_valid, 1'b0);
        step();
        @(negedge clk);
        chk("abort_idle", ctl, 9'd0);
        step();
        mem_resp_valid = 0;

        // Reset mid-read after 2 of 4 beats
        ic_req_valid = 1; ic_req_addr = 28'h0000055;
        step();
        step();
        ic_req_valid = 0; mem_resp_valid = 1;
        step();
        step();
        reset = 0;
        #1;
        chk("midrst_ctl", ctl, 9'd0);
        chk("midrst_addr", mem_req_addr, 28'd0);
        step();
        reset = 1; mem_resp_valid = 0;
        dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h0000077;
        step();
        step();
        dc_req_valid = 0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            mem_resp_valid = (i < 4);
            @(negedge clk);
            if (dc_resp_valid) n++;
            step();
        end
        chk("postrst_rd_count", n, 4);

        // Simultaneous requests held continuously
        reset = 0;
        step();
        reset = 1;
        step();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = '{1, 0, 1, 0};
`else
        exp_order = '{1, 1, 1, 0};
`endif
        mem_req_ready = 1; mem_resp_valid = 1; mem_req_data_ready = 1;
        ic_req_valid = 1; ic_req_rw = 0; dc_req_valid = 1; dc_req_rw = 0;
        for (int t = 0; t < 4; t++) begin
            if (t == 3) dc_req_valid = 0;
            next_grant(who);
            chk($sformatf("tie_grant%0d", t), who, exp_order[t]);
        end
        ic_req_valid = 0; mem_resp_valid = 0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
